// File: rtl/cipher_pkg.sv
// Shared types and helpers for the iterative 8-bit round cipher.
// Round key: rotl(key, i mod 8) ^ i.
package cipher_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cipher_state_e;

    // Wrap-around left rotation by 0..7.
    function automatic logic [BYTE_W-1:0] rotl(input logic [BYTE_W-1:0] x, input logic [2:0] n);
        logic [2*BYTE_W-1:0] w_dbl;
        w_dbl = {x, x} << n;
        return w_dbl[2*BYTE_W-1:BYTE_W];
    endfunction

    function automatic logic [BYTE_W-1:0] rotr1(input logic [BYTE_W-1:0] x);
        return {x[0], x[BYTE_W-1:1]};
    endfunction

    function automatic logic [BYTE_W-1:0] rotl1(input logic [BYTE_W-1:0] x);
        return {x[BYTE_W-2:0], x[BYTE_W-1]};
    endfunction

    function automatic logic [BYTE_W-1:0] rk(input logic [BYTE_W-1:0] key, input logic [BYTE_W-1:0] i);
        return rotl(key, i[2:0]) ^ i;
    endfunction

endpackage

// File: rtl/cipher_round_engine_if.sv
// Byte-in / byte-out valid/ready bus of the cipher engine.
interface cipher_round_engine_if;
    import cipher_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_data;
    logic [BYTE_W-1:0] in_key;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/cipher_round_engine_round.sv
// Single combinational cipher round; dir=0 encrypts, dir=1 decrypts.
// In an encrypt-only build the top ties dir low and the decrypt leg folds away.
module cipher_round
    import cipher_pkg::*;
(
    input  logic [BYTE_W-1:0] i_s,
    input  logic [BYTE_W-1:0] i_rk,
    input  logic              i_dir,
    output logic [BYTE_W-1:0] o_s
);

    // Decrypt undoes encrypt: rotate left first, then strip the round key.
    always_comb begin
        o_s = rotr1(i_s ^ i_rk);
        if (i_dir) begin
            o_s = rotl1(i_s) ^ i_rk;
        end
    end

endmodule

// File: rtl/cipher_round_engine.sv
// Iterative round cipher: accept a byte+key, run ROUNDS rounds (one per
// clock), then hold the result until the consumer takes it.
// Optional macro CIPHER_DECRYPT_EN adds the mode port and decrypt direction.
module cipher_round_engine
    import cipher_pkg::*;
#(
    parameter int ROUNDS = 4,
    parameter int RW     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef CIPHER_DECRYPT_EN
    input  logic                 mode,
`endif
    cipher_round_engine_if.slave bus,
    output logic                 busy
);

    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

    cipher_state_e     r_fsm, w_next_fsm;
    logic [BYTE_W-1:0] r_state;
    logic [BYTE_W-1:0] r_key;
    logic [RW-1:0]     r_cnt;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_busy;
    logic              w_accept;
    logic              w_dir;
    logic              w_last;
    logic [RW-1:0]     w_start;
    logic [BYTE_W-1:0] w_rk;
    logic [BYTE_W-1:0] w_round;

`ifdef CIPHER_DECRYPT_EN
    logic r_mode;

    // Direction is frozen at accept so a mid-block mode change is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_mode <= 1'b0;
        else if (w_accept) r_mode <= mode;
    end

    assign w_dir   = r_mode;
    assign w_start = mode ? LAST : '0;
`else
    assign w_dir   = 1'b0;
    assign w_start = '0;
`endif

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_last   = w_dir ? (r_cnt == '0) : (r_cnt == LAST);
    assign w_rk     = rk(r_key, BYTE_W'(r_cnt));

    cipher_round u_round (
        .i_s   (r_state),
        .i_rk  (w_rk),
        .i_dir (w_dir),
        .o_s   (w_round)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= ST_IDLE;
        else        r_fsm <= w_next_fsm;
    end

    // Next state and handshake outputs; ready only in IDLE, valid only in DONE.
    always_comb begin
        w_next_fsm  = r_fsm;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next_fsm = ST_RUN;
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_next_fsm = ST_DONE;
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next_fsm = ST_IDLE;
            end
            default: w_next_fsm = ST_IDLE;
        endcase
    end

    // Block state, key and round index; the counter parks on the last index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_key   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= bus.in_data;
            r_key   <= bus.in_key;
            r_cnt   <= w_start;
        end else if (r_fsm == ST_RUN) begin
            r_state <= w_round;
            if (!w_last) r_cnt <= w_dir ? (r_cnt - RW'(1)) : (r_cnt + RW'(1));
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_state;
    assign busy          = w_busy;

endmodule

// File: tb/tb_cipher_round_engine.sv
// Scoreboard bench for cipher_round_engine: three instances (ROUNDS=1,2,4).
// Stimulus pushes expected bytes; per-instance monitors check accepts,
// latency and output data independently.
module tb_cipher_round_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    logic       vld [3];
    logic       rdy [3];
    logic       ordy[3];
    logic       ov  [3];
    logic       bsy [3];
    logic       md  [3];
    logic [7:0] din [3];
    logic [7:0] kin [3];
    logic [7:0] od  [3];

    logic [7:0] exp_q[3][$];
    int         acc_q[3][$];
    int         last_acc[3];
    logic       b2b_chk = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Spec-level reference: rk = rotl(k, i%8) ^ i, s = rotr1(s ^ rk).
    function automatic logic [7:0] model(input logic [7:0] d, input logic [7:0] k, input int r);
        logic [7:0]  s;
        logic [7:0]  rkv;
        logic [15:0] dd;
        s = d;
        for (int i = 0; i < r; i++) begin
            dd  = {k, k} << (i % 8);
            rkv = dd[15:8] ^ 8'(i);
            s   = s ^ rkv;
            s   = {s[0], s[7:1]};
        end
        return s;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int R = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

        cipher_round_engine_if ifc ();

        assign ifc.in_valid  = vld[g];
        assign ifc.in_data   = din[g];
        assign ifc.in_key    = kin[g];
        assign ifc.out_ready = ordy[g];
        assign rdy[g]        = ifc.in_ready;
        assign ov[g]         = ifc.out_valid;
        assign od[g]         = ifc.out_data;

        cipher_round_engine #(.ROUNDS(R), .RW(8)) dut (
            .clk   (clk),
            .rst_n (rst_n),
`ifdef CIPHER_DECRYPT_EN
            .mode  (md[g]),
`endif
            .bus   (ifc),
            .busy  (bsy[g])
        );

        logic pv = 1'b0;

        // Monitor: records accepts, checks latency on out_valid rise and data on handshake.
        always @(negedge clk) begin
            if (rst_n) begin
                if (vld[g] && rdy[g]) begin
                    acc_q[g].push_back(cyc + 1);
                    if (b2b_chk) begin
                        if (last_acc[g] >= 0) chk($sformatf("b2b_interval[%0d]", g), cyc + 1 - last_acc[g], R + 2);
                        last_acc[g] = cyc + 1;
                    end
                end
                if (ov[g] && !pv) begin
                    if (acc_q[g].size() == 0) fail($sformatf("out_valid_without_accept[%0d]", g));
                    else chk($sformatf("latency[%0d]", g), cyc - acc_q[g].pop_front(), R);
                end
                if (ov[g] && ordy[g]) begin
                    if (exp_q[g].size() == 0) fail($sformatf("unexpected_output[%0d] data=%0h", g, od[g]));
                    else chk($sformatf("out_data[%0d]", g), {24'd0, od[g]}, {24'd0, exp_q[g].pop_front()});
                end
            end
            pv = ov[g] & rst_n;
        end
    end

    // Call at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input int g, input logic [7:0] d, input logic [7:0] k,
                        input logic m, input logic [7:0] e);
        int n;
        vld[g] = 1'b1;
        din[g] = d;
        kin[g] = k;
        md[g]  = m;
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy[g]) break;
            n++;
            if (n > 200) begin
                fail($sformatf("accept_timeout[%0d]", g));
                vld[g] = 1'b0;
                return;
            end
        end
        exp_q[g].push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        for (int g = 0; g < 3; g++) begin
            exp_q[g].delete();
            acc_q[g].delete();
            last_acc[g] = -1;
        end
    endtask

    logic [7:0] tv_d[8];
    logic [7:0] tv_k[8];

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        tv_d = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h5A, 8'hC3, 8'h7E, 8'h12};
        tv_k = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h80, 8'h3C, 8'hE7, 8'h69};
        for (int g = 0; g < 3; g++) begin
            vld[g] = 1'b0; ordy[g] = 1'b1; md[g] = 1'b0; din[g] = 8'h00; kin[g] = 8'h00;
        end
        clear_sb();

        // Reset values while reset is held.
        #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_in_ready[%0d]", g), {31'd0, rdy[g]}, 1);
            chk($sformatf("rst_out_valid[%0d]", g), {31'd0, ov[g]}, 0);
            chk($sformatf("rst_busy[%0d]", g), {31'd0, bsy[g]}, 0);
            chk($sformatf("rst_out_data[%0d]", g), {24'd0, od[g]}, 0);
        end
        #11 rst_n = 1'b1;
        idle(1);

        // ROUNDS=1 single round.
        send(0, 8'h01, 8'h00, 1'b0, 8'h80);
        vld[0] = 1'b0;

        // ROUNDS=2 encrypt; inputs scrambled after accept must not matter.
        send(1, 8'h3C, 8'hA5, 1'b0, 8'h43);
        vld[1] = 1'b0;
        din[1] = 8'hFF;
        kin[1] = 8'hFF;
`ifdef CIPHER_DECRYPT_EN
        send(1, 8'h43, 8'hA5, 1'b1, 8'h3C);
        vld[1] = 1'b0;
        md[1]  = 1'b0;
`endif
        idle(8);

        // Backpressure on ROUNDS=2: 0x5A/0x0F -> 0xAA -> 0xDA.
        ordy[1] = 1'b0;
        send(1, 8'h5A, 8'h0F, 1'b0, 8'hDA);
        vld[1] = 1'b0;
        n = 0;
        while (!ov[1] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail("bp_out_valid_timeout");
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            vld[1] = ~vld[1];
            din[1] = 8'(c * 37);
            kin[1] = 8'(c * 11);
            @(negedge clk);
            chk("bp_out_data_stable", {24'd0, od[1]}, 32'hDA);
            chk("bp_in_ready_low", {31'd0, rdy[1]}, 0);
            chk("bp_out_valid_held", {31'd0, ov[1]}, 1);
            @(posedge clk); #1;
        end
        vld[1] = 1'b0;
        ordy[1] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_idle_in_ready", {31'd0, rdy[1]}, 1);
        chk("bp_idle_out_valid", {31'd0, ov[1]}, 0);
        chk("bp_idle_busy", {31'd0, bsy[1]}, 0);
        chk("bp_single_handshake", exp_q[1].size(), 0);
        chk("bp_no_second_accept", acc_q[1].size(), 0);
        @(posedge clk); #1;

        // Reset during RUN on ROUNDS=4, then a fresh block 0x3C/0xA5 -> 0xE2.
        send(2, 8'h3C, 8'hA5, 1'b0, 8'hE2);
        vld[2] = 1'b0;
        idle(1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, ov[2]}, 0);
        chk("midrst_busy", {31'd0, bsy[2]}, 0);
        chk("midrst_in_ready", {31'd0, rdy[2]}, 1);
        chk("midrst_out_data", {24'd0, od[2]}, 0);
        clear_sb();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(2, 8'h3C, 8'hA5, 1'b0, 8'hE2);
        vld[2] = 1'b0;
        idle(10);

        // Back-to-back on ROUNDS=4 with in_valid and out_ready held high.
        b2b_chk = 1'b1;
        for (int i = 0; i < 8; i++) send(2, tv_d[i], tv_k[i], 1'b0, model(tv_d[i], tv_k[i], 4));
        vld[2] = 1'b0;
        idle(20);
        b2b_chk = 1'b0;

        for (int g = 0; g < 3; g++) begin
            chk($sformatf("drain_exp[%0d]", g), exp_q[g].size(), 0);
            chk($sformatf("drain_acc[%0d]", g), acc_q[g].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cipher_round_engine.md
Name: cipher_round_engine

Overview:
Iterative 8-bit block cipher core wrapped around the one-bit circular-rotate datapath stage.
- Accepts a plaintext byte and an 8-bit key over a valid/ready handshake.
- Applies ROUNDS rounds of "XOR with round key, then rotate right by 1", one round per clock.
- Presents the ciphertext byte over a valid/ready handshake.
- Sits between the UART/byte-input front end and the output formatter of the 8-bit cryptosystem.

Parameters:
- ROUNDS, 4, number of cipher rounds; legal range 1..255.
- RW, 8, round-counter width; must satisfy 2^RW > ROUNDS-1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_key valid
- in_ready  output  1  engine can accept a block
- in_data  input  8  plaintext (or ciphertext when decrypting)
- in_key  input  8  cipher key, sampled with in_data
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  8  result byte
- busy  output  1  high in RUN or DONE
- mode  input  1  0 = encrypt, 1 = decrypt (present only with CIPHER_DECRYPT_EN)

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n). Reset mid-operation aborts the block and discards it.
- Reset values:
  - FSM = IDLE
  - state register, key register, round counter, out_data = 0
  - out_valid = 0, busy = 0, in_ready = 1
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready, latch in_data into state, in_key into key, mode into mode_q; set round counter (0 for encrypt, ROUNDS-1 for decrypt); go to RUN.
  - RUN: in_ready = 0. Each cycle applies one round at index i = counter.
    - Encrypt advances the counter upward; on the edge applying i = ROUNDS-1, go to DONE.
    - Decrypt advances the counter downward; on the edge applying i = 0, go to DONE.
  - DONE: out_valid = 1 and out_data = state, held stable until out_ready. On out_valid & out_ready, go to IDLE and clear out_valid.
  - in_valid is ignored outside IDLE, and no new block is accepted in the DONE handshake cycle.
- Latency: out_valid rises exactly ROUNDS cycles after the accept edge.
- Throughput: one block per ROUNDS+2 cycles when out_ready is held high.
- Round key: rk_i = rotl(key, i mod 8) XOR i[7:0], all 8-bit, wrap-around rotation.
- Encrypt round: s' = rotr1(s XOR rk_i), where rotr1(x) = {x[0], x[7:1]}.
- Decrypt round: s' = rotl1(s) XOR rk_i, where rotl1(x) = {x[6:0], x[7]}.
- Boundary conditions:
  - ROUNDS = 1: a single RUN cycle, then DONE.
  - in_data/in_key changes after the accept edge have no effect.
  - out_ready held low keeps the engine in DONE indefinitely with out_data stable.

Optional Feature:
CIPHER_DECRYPT_EN.
- Defined: mode port exists, is sampled at accept, and selects the decrypt round and counter direction.
- Undefined: no mode port; encrypt only; the decrypt datapath and mode_q are not synthesised.

Decomposition:
- Shared package cipher_pkg holds:
  - FSM state typedef (IDLE/RUN/DONE encoding)
  - BYTE_W = 8
  - rotl/rotr helper functions
  - round-key function rk(key, i)
- One natural sub-module: cipher_round, a combinational single-round datapath with inputs s, rk, dir and output s'. It is instantiated once and reused every cycle.

Test Plan:
1. ROUNDS=1, key=0x00, data=0x01, out_ready=1 -> out_valid 1 cycle after accept, out_data=0x80.
2. ROUNDS=2, key=0xA5, data=0x3C, encrypt -> out_data=0x43, 2 cycles after accept.
3. With CIPHER_DECRYPT_EN: ROUNDS=2, key=0xA5, data=0x43, mode=1 -> out_data=0x3C.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE, toggle in_valid -> out_data stable, in_ready=0, no second accept; raise out_ready -> one handshake, then IDLE with in_ready=1.
5. Assert rst_n low during RUN (ROUNDS=4, cycle 2) -> immediately out_valid=0, busy=0, in_ready=1, out_data=0x00; a fresh block then completes correctly.
6. Back-to-back blocks with in_valid and out_ready held high, 8 random bytes, ROUNDS=4 -> accept every 6 cycles; results match the reference model byte for byte.
